// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - instruction-fetch responder and MEM-port arbiter over a byte-wide synchronous RAM
module mem_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_i,
    input  logic [ADDR_W-1:0] pc_i,
    output logic              if_busy_o,
    output logic [31:0]       inst_o,
    output logic              inst_valid_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [1:0]        mem_len_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [31:0]       mem_wdata_i,
    output logic              mem_busy_o,
    output logic [31:0]       mem_rdata_o,
    output logic              mem_done_o,
    input  logic [7:0]        ram_din_i,
    output logic [7:0]        ram_dout_o,
    output logic [ADDR_W-1:0] ram_a_o,
    output logic              ram_wr_o
);
    typedef enum logic [2:0] {S_IDLE, S_READ, S_RLAST, S_WRITE, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [1:0]        last_q, last_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [31:0]       asm_q, asm_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              own_if_q, own_if_d;
    logic              pend_if_q, pend_if_d;
    logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
    logic [31:0]       inst_q, inst_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [1:0]        prev_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            base_q    <= '0;
            last_q    <= '0;
            cnt_q     <= '0;
            asm_q     <= '0;
            wdata_q   <= '0;
            own_if_q  <= 1'b0;
            pend_if_q <= 1'b0;
            pend_pc_q <= '0;
            inst_q    <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            asm_q     <= asm_d;
            wdata_q   <= wdata_d;
            own_if_q  <= own_if_d;
            pend_if_q <= pend_if_d;
            pend_pc_q <= pend_pc_d;
            inst_q    <= inst_d;
            rdata_q   <= rdata_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        asm_d     = asm_q;
        wdata_d   = wdata_q;
        own_if_d  = own_if_q;
        pend_if_d = pend_if_q;
        pend_pc_d = pend_pc_q;
        inst_d    = inst_q;
        rdata_d   = rdata_q;
        prev_idx  = cnt_q - 2'd1;
        case (state_q)
            S_IDLE: begin
                // MEM has priority; a simultaneous fetch is parked in the single pending slot
                if (mem_req_i) begin
                    own_if_d = 1'b0;
                    base_d   = mem_addr_i;
                    wdata_d  = mem_wdata_i;
                    last_d   = (mem_len_i == 2'd0) ? 2'd0 : (mem_len_i == 2'd1) ? 2'd1 : 2'd3;
                    cnt_d    = 2'd0;
                    asm_d    = '0;
                    state_d  = mem_we_i ? S_WRITE : S_READ;
                    if (if_i) begin
                        pend_if_d = 1'b1;
                        pend_pc_d = pc_i;
                    end
                end else if (pend_if_q || if_i) begin
                    own_if_d  = 1'b1;
                    base_d    = pend_if_q ? pend_pc_q : pc_i;
                    pend_if_d = 1'b0;
                    last_d    = 2'd3;
                    cnt_d     = 2'd0;
                    asm_d     = '0;
                    state_d   = S_READ;
                end
            end
            S_READ: begin
                if (cnt_q != 2'd0) asm_d[{prev_idx, 3'b000} +: 8] = ram_din_i;
                if (cnt_q == last_q) state_d = S_RLAST;
                else                 cnt_d   = cnt_q + 2'd1;
            end
            S_RLAST: begin
                asm_d[{cnt_q, 3'b000} +: 8] = ram_din_i;
                if (own_if_q) inst_d  = asm_d;
                else          rdata_d = asm_d;
                state_d = S_DONE;
            end
            S_WRITE: begin
                if (cnt_q == last_q) state_d = S_DONE;
                else                 cnt_d   = cnt_q + 2'd1;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ram_a_o      = '0;
        ram_wr_o     = 1'b0;
        ram_dout_o   = '0;
        inst_valid_o = 1'b0;
        mem_done_o   = 1'b0;
        if (state_q == S_READ || state_q == S_RLAST || state_q == S_WRITE)
            ram_a_o = base_q + {{(ADDR_W-2){1'b0}}, cnt_q};
        if (state_q == S_WRITE) begin
            ram_wr_o   = 1'b1;
            ram_dout_o = wdata_q[{cnt_q, 3'b000} +: 8];
        end
        if (state_q == S_DONE) begin
            inst_valid_o = own_if_q;
            mem_done_o   = !own_if_q;
        end
        if_busy_o   = (state_q != S_IDLE) || pend_if_q;
        mem_busy_o  = (state_q != S_IDLE);
        inst_o      = inst_q;
        mem_rdata_o = rdata_q;
    end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - scoreboard bench for mem_ctrl with a byte-wide synchronous RAM model
module tb_mem_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_i = 1'b0;
    logic [31:0] pc_i = '0;
    logic        if_busy_o;
    logic [31:0] inst_o;
    logic        inst_valid_o;
    logic        mem_req_i = 1'b0;
    logic        mem_we_i = 1'b0;
    logic [1:0]  mem_len_i = '0;
    logic [31:0] mem_addr_i = '0;
    logic [31:0] mem_wdata_i = '0;
    logic        mem_busy_o;
    logic [31:0] mem_rdata_o;
    logic        mem_done_o;
    logic [7:0]  ram_din_i = '0;
    logic [7:0]  ram_dout_o;
    logic [31:0] ram_a_o;
    logic        ram_wr_o;

    mem_ctrl #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .if_i(if_i), .pc_i(pc_i), .if_busy_o(if_busy_o), .inst_o(inst_o), .inst_valid_o(inst_valid_o),
        .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_len_i(mem_len_i), .mem_addr_i(mem_addr_i),
        .mem_wdata_i(mem_wdata_i), .mem_busy_o(mem_busy_o), .mem_rdata_o(mem_rdata_o), .mem_done_o(mem_done_o),
        .ram_din_i(ram_din_i), .ram_dout_o(ram_dout_o), .ram_a_o(ram_a_o), .ram_wr_o(ram_wr_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: bytes never written come from a fixed preload table
    logic [7:0] ram [0:1023];
    logic       written [0:1023];
    logic       tb_init = 1'b1;

    function automatic logic [7:0] init_byte(input logic [9:0] a);
        case (a)
            10'h100: return 8'h13;
            10'h101: return 8'h05;
            10'h102: return 8'h50;
            10'h103: return 8'h00;
            10'h3FF: return 8'h5A;
            10'h000: return 8'hC3;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] rd(input logic [9:0] a);
        return written[a] ? ram[a] : init_byte(a);
    endfunction

    always @(posedge clk) begin
        if (tb_init) begin
            for (int i = 0; i < 1024; i++) written[i] <= 1'b0;
        end else if (ram_wr_o) begin
            ram[ram_a_o[9:0]]     <= ram_dout_o;
            written[ram_a_o[9:0]] <= 1'b1;
        end
        ram_din_i <= rd(ram_a_o[9:0]);
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        bit          is_if;
        bit          chk_data;
        logic [31:0] data;
        int          cyc;
    } exp_t;
    exp_t sbq[$];

    always @(negedge clk) begin
        if (!rst && (inst_valid_o || mem_done_o)) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected: pulse inst_valid=%0b mem_done=%0b with empty scoreboard", inst_valid_o, mem_done_o);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("sb_kind_if", {31'd0, inst_valid_o}, {31'd0, e.is_if});
                chk("sb_both_pulses", {31'd0, inst_valid_o & mem_done_o}, 32'd0);
                chk("sb_cycle", cyc, e.cyc);
                if (e.chk_data) chk(e.is_if ? "sb_inst" : "sb_rdata", e.is_if ? inst_o : mem_rdata_o, e.data);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((if_busy_o || mem_busy_o) && n < 60) begin
            step();
            n++;
        end
        if (if_busy_o || mem_busy_o) begin
            checks++;
            failures++;
            $display("FAIL wait_idle: timeout busy if=%0b mem=%0b", if_busy_o, mem_busy_o);
        end
    endtask

    task automatic push(input bit is_if, input bit cd, input logic [31:0] d, input int c);
        exp_t e;
        e.is_if = is_if; e.chk_data = cd; e.data = d; e.cyc = c;
        sbq.push_back(e);
    endtask

    task automatic fetch(input logic [31:0] pc, output int acc);
        wait_idle();
        if_i = 1'b1; pc_i = pc;
        step();
        acc = cyc;
        if_i = 1'b0; pc_i = 32'hBAD0_0000;
    endtask

    task automatic mem_op(input bit we, input logic [1:0] len, input logic [31:0] addr,
                          input logic [31:0] wd, output int acc);
        wait_idle();
        mem_req_i = 1'b1; mem_we_i = we; mem_len_i = len; mem_addr_i = addr; mem_wdata_i = wd;
        step();
        acc = cyc;
        mem_req_i = 1'b0; mem_we_i = ~we; mem_len_i = 2'd0; mem_addr_i = 32'hBAD0_0000; mem_wdata_i = '0;
    endtask

    logic [31:0] st_data;
    logic [7:0]  st_byte;

    initial begin
        int acc;
        #2;
        chk("rst_if_busy", {31'd0, if_busy_o}, 32'd0);
        chk("rst_mem_busy", {31'd0, mem_busy_o}, 32'd0);
        chk("rst_ram_wr", {31'd0, ram_wr_o}, 32'd0);
        chk("rst_ram_a", ram_a_o, 32'd0);
        chk("rst_inst", inst_o, 32'd0);
        chk("rst_rdata", mem_rdata_o, 32'd0);
        step(); step();
        rst = 1'b0; tb_init = 1'b0;
        step();

        // word fetch: addresses in cycles 1-4, valid in cycle 6
        fetch(32'h100, acc);
        push(1'b1, 1'b1, 32'h0050_0513, acc + 5);
        for (int k = 1; k <= 6; k++) begin
            if (k <= 4) chk($sformatf("fetch_a_c%0d", k), ram_a_o, 32'h100 + k - 1);
            chk($sformatf("fetch_busy_c%0d", k), {31'd0, if_busy_o}, 32'd1);
            chk($sformatf("fetch_nowr_c%0d", k), {31'd0, ram_wr_o}, 32'd0);
            if (k < 6) step();
        end
        step();
        chk("fetch_idle_busy", {31'd0, if_busy_o}, 32'd0);
        chk("fetch_idle_a", ram_a_o, 32'd0);

        // word store 0xDEADBEEF at 0x200
        st_data = 32'hDEAD_BEEF;
        mem_op(1'b1, 2'd2, 32'h200, st_data, acc);
        push(1'b0, 1'b0, 32'd0, acc + 4);
        for (int k = 1; k <= 4; k++) begin
            st_byte = st_data[8*(k-1) +: 8];
            chk($sformatf("st_wr_c%0d", k), {31'd0, ram_wr_o}, 32'd1);
            chk($sformatf("st_a_c%0d", k), ram_a_o, 32'h200 + k - 1);
            chk($sformatf("st_dout_c%0d", k), {24'd0, ram_dout_o}, {24'd0, st_byte});
            step();
        end
        chk("st_wr_done", {31'd0, ram_wr_o}, 32'd0);
        chk("st_busy_done", {31'd0, mem_busy_o}, 32'd1);
        wait_idle();
        chk("st_ram_200", {24'd0, rd(10'h200)}, 32'hEF);
        chk("st_ram_203", {24'd0, rd(10'h203)}, 32'hDE);

        mem_op(1'b0, 2'd2, 32'h200, 32'd0, acc);
        push(1'b0, 1'b1, 32'hDEAD_BEEF, acc + 5);
        mem_op(1'b0, 2'd0, 32'h203, 32'd0, acc);
        push(1'b0, 1'b1, 32'h0000_00DE, acc + 2);
        mem_op(1'b0, 2'd1, 32'h202, 32'd0, acc);
        push(1'b0, 1'b1, 32'h0000_DEAD, acc + 3);
        mem_op(1'b0, 2'd3, 32'h200, 32'd0, acc);
        push(1'b0, 1'b1, 32'hDEAD_BEEF, acc + 5);

        // simultaneous: MEM load first, parked fetch accepted at end of the cycle after DONE
        wait_idle();
        if_i = 1'b1; pc_i = 32'h100;
        mem_req_i = 1'b1; mem_we_i = 1'b0; mem_len_i = 2'd2; mem_addr_i = 32'h200;
        step();
        acc = cyc;
        if_i = 1'b0; pc_i = 32'h0; mem_req_i = 1'b0; mem_addr_i = 32'h0;
        push(1'b0, 1'b1, 32'hDEAD_BEEF, acc + 5);
        push(1'b1, 1'b1, 32'h0050_0513, acc + 12);
        for (int k = 1; k <= 13; k++) begin
            chk($sformatf("sim_ifbusy_c%0d", k), {31'd0, if_busy_o}, 32'd1);
            if (k == 1) chk("sim_mem_first_a", ram_a_o, 32'h200);
            if (k == 7) chk("sim_gap_idle_a", ram_a_o, 32'h0);
            if (k == 8) chk("sim_fetch_a", ram_a_o, 32'h100);
            step();
        end
        chk("sim_ifbusy_end", {31'd0, if_busy_o}, 32'd0);

        // wrap-around half load
        mem_op(1'b0, 2'd1, 32'hFFFF_FFFF, 32'd0, acc);
        push(1'b0, 1'b1, 32'h0000_C35A, acc + 3);
        chk("wrap_a_c1", ram_a_o, 32'hFFFF_FFFF);
        step();
        chk("wrap_a_c2", ram_a_o, 32'h0000_0000);
        wait_idle();

        // reset in cycle 2 of a word store
        mem_op(1'b1, 2'd2, 32'h300, 32'h1234_5678, acc);
        step();
        chk("rstmid_wr_before", {31'd0, ram_wr_o}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rstmid_wr", {31'd0, ram_wr_o}, 32'd0);
        chk("rstmid_mem_busy", {31'd0, mem_busy_o}, 32'd0);
        chk("rstmid_if_busy", {31'd0, if_busy_o}, 32'd0);
        chk("rstmid_done", {31'd0, mem_done_o}, 32'd0);
        chk("rstmid_a", ram_a_o, 32'd0);
        step();
        rst = 1'b0;
        step();
        fetch(32'h100, acc);
        push(1'b1, 1'b1, 32'h0050_0513, acc + 5);
        chk("post_rst_a", ram_a_o, 32'h100);
        wait_idle();
        step(); step();
        chk("sb_drained", sbq.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end
endmodule
